// File: rtl/vgroup_retire.sv
// vgroup_retire: tracks one grouped vector instruction (LMUL register group)
// from issue until every micro-op result of the group has been retired into
// the vector register file. Results must arrive in register order starting
// at the group base; out-of-order results are dropped and flagged.
module vgroup_retire #(
   parameter int DATA_W   = 32,
   parameter int MAX_LMUL = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [2:0]        issue_lmul,
   input  logic [4:0]        issue_rdest,
   output logic              issue_ready,
   input  logic              res_valid,
   input  logic [4:0]        res_rdest,
   input  logic [DATA_W-1:0] res_data,
   output logic              res_ready,
   output logic              wr_en,
   output logic [4:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              group_done,
   output logic              err_seq,
   output logic              front_stall
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      DONE    = 2'b10
   } state_t;

   // Group size used for the reserved encodings 1xx.
   localparam logic [3:0] MAX_TOTAL = 4'(MAX_LMUL);

   // Translate the encoded LMUL into the number of result words in the group.
   function automatic logic [3:0] decode_lmul(input logic [2:0] enc);
      logic [3:0] n;
      case (enc)
         3'b000:  n = 4'd1;
         3'b001:  n = 4'd2;
         3'b010:  n = 4'd4;
         3'b011:  n = 4'd8;
         default: n = MAX_TOTAL;
      endcase
      return n;
   endfunction

   state_t            state_r;
   logic [4:0]        base_r;
   logic [3:0]        total_r;
   logic [3:0]        count_r;
   logic              issue_ready_r;
   logic              res_ready_r;
   logic              wr_en_r;
   logic [4:0]        wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              group_done_r;
   logic              err_seq_r;
   logic              front_stall_r;

   logic [4:0]        exp_reg_s;
   logic [3:0]        count_inc_s;
   logic              issue_hs_s;
   logic              res_hs_s;
   logic              match_s;
   logic              last_s;

   // Handshake qualification and the register the next result must target;
   // the 5-bit add wraps v31 -> v0 naturally.
   always_comb begin
      exp_reg_s   = base_r + {1'b0, count_r};
      count_inc_s = count_r + 4'd1;
      issue_hs_s  = issue_valid & issue_ready_r;
      res_hs_s    = res_valid & res_ready_r;
      match_s     = (res_rdest == exp_reg_s);
      last_s      = (count_inc_s == total_r);
   end

   // Retirement FSM; every output is a flop updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         base_r        <= 5'd0;
         total_r       <= 4'd0;
         count_r       <= 4'd0;
         issue_ready_r <= 1'b1;
         res_ready_r   <= 1'b0;
         wr_en_r       <= 1'b0;
         wr_addr_r     <= 5'd0;
         wr_data_r     <= '0;
         group_done_r  <= 1'b0;
         err_seq_r     <= 1'b0;
         front_stall_r <= 1'b0;
      end else begin
         // Pulses last one cycle unless re-armed below.
         wr_en_r      <= 1'b0;
         err_seq_r    <= 1'b0;
         group_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (issue_hs_s) begin
                  base_r        <= issue_rdest;
                  total_r       <= decode_lmul(issue_lmul);
                  count_r       <= 4'd0;
                  state_r       <= COLLECT;
                  issue_ready_r <= 1'b0;
                  res_ready_r   <= 1'b1;
                  front_stall_r <= 1'b1;
               end
            end
            COLLECT: begin
               if (res_hs_s) begin
                  count_r <= count_inc_s;
                  if (match_s) begin
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= exp_reg_s;
                     wr_data_r <= res_data;
                  end else begin
                     err_seq_r <= 1'b1;
                  end
                  if (last_s) begin
                     state_r      <= DONE;
                     res_ready_r  <= 1'b0;
                     group_done_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_r       <= IDLE;
               issue_ready_r <= 1'b1;
               front_stall_r <= 1'b0;
            end
            default: begin
               state_r       <= IDLE;
               issue_ready_r <= 1'b1;
               res_ready_r   <= 1'b0;
               front_stall_r <= 1'b0;
            end
         endcase
      end
   end

   assign issue_ready = issue_ready_r;
   assign res_ready   = res_ready_r;
   assign wr_en       = wr_en_r;
   assign wr_addr     = wr_addr_r;
   assign wr_data     = wr_data_r;
   assign group_done  = group_done_r;
   assign err_seq     = err_seq_r;
   assign front_stall = front_stall_r;

endmodule

// File: tb/tb_vgroup_retire.sv
// Self-checking bench for vgroup_retire: expected write/error/done events are
// queued as results are driven and popped when the DUT pulses its outputs.
module tb_vgroup_retire;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic [2:0]  issue_lmul = 3'd0;
   logic [4:0]  issue_rdest = 5'd0;
   logic        issue_ready;
   logic        res_valid = 1'b0;
   logic [4:0]  res_rdest = 5'd0;
   logic [31:0] res_data = 32'd0;
   logic        res_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        group_done;
   logic        err_seq;
   logic        front_stall;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic        err;
      logic        done;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   vgroup_retire #(.DATA_W(32), .MAX_LMUL(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_lmul(issue_lmul), .issue_rdest(issue_rdest),
      .issue_ready(issue_ready),
      .res_valid(res_valid), .res_rdest(res_rdest), .res_data(res_data),
      .res_ready(res_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .group_done(group_done), .err_seq(err_seq), .front_stall(front_stall)
   );

   always #5 clk = ~clk;

   // Scoreboard: every output event must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (wr_en || err_seq || group_done)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got wr_en=%0b err_seq=%0b group_done=%0b addr=%0d required no event",
                     wr_en, err_seq, group_done, wr_addr);
         end else begin
            e = exp_q.pop_front();
            if ({wr_en, err_seq, group_done} !== {e.wr, e.err, e.done} ||
                (e.wr && (wr_addr !== e.addr || wr_data !== e.data))) begin
               errors++;
               $display("FAIL sb_event got wr=%0b err=%0b done=%0b addr=%0d data=%h required wr=%0b err=%0b done=%0b addr=%0d data=%h",
                        wr_en, err_seq, group_done, wr_addr, wr_data,
                        e.wr, e.err, e.done, e.addr, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_issue(input logic [2:0] lmul, input logic [4:0] rdest);
      issue_valid = 1'b1;
      issue_lmul  = lmul;
      issue_rdest = rdest;
      tick();
      issue_valid = 1'b0;
   endtask

   // Drive one result for a cycle and queue what the DUT must report for it.
   task automatic send_res(input logic [4:0] rdest, input logic [31:0] data,
                           input logic wr, input logic done);
      exp_t e;
      e.wr = wr; e.err = ~wr; e.done = done; e.addr = rdest; e.data = data;
      exp_q.push_back(e);
      res_valid = 1'b1;
      res_rdest = rdest;
      res_data  = data;
      tick();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({wr_en, err_seq, group_done, front_stall, res_ready, issue_ready, wr_addr, wr_data} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_state got wr=%0b err=%0b done=%0b stall=%0b rrdy=%0b irdy=%0b addr=%0d data=%h required all 0 except irdy=1",
                  wr_en, err_seq, group_done, front_stall, res_ready, issue_ready, wr_addr, wr_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lmul4();
      int stall;
      stall = 0;
      checks++;
      if (front_stall !== 1'b0 || issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL lmul4_pre got stall=%0b irdy=%0b required 0 1", front_stall, issue_ready);
      end
      do_issue(3'b010, 5'd4);
      if (front_stall) stall++;
      for (int i = 0; i < 4; i++) begin
         send_res(5'(4 + i), $urandom, 1'b1, i == 3);
         if (front_stall) stall++;
      end
      res_valid = 1'b0;
      tick();
      checks++;
      if (front_stall !== 1'b0) begin
         errors++;
         $display("FAIL lmul4_release got stall=%0b required 0", front_stall);
      end
      checks++;
      if (stall !== 5) begin
         errors++;
         $display("FAIL lmul4_stall_cycles got %0d required 5", stall);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL lmul4_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int stall;
      stall = 0;
      do_issue(3'b011, 5'd28);
      if (front_stall) stall++;
      for (int i = 0; i < 8; i++) begin
         send_res(5'(28 + i), $urandom, 1'b1, i == 7);
         if (front_stall) stall++;
      end
      res_valid = 1'b0;
      tick();
      checks++;
      if (stall !== 9 || issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_stall got stall=%0d irdy=%0b required 9 1", stall, issue_ready);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL wrap_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_mismatch();
      do_issue(3'b001, 5'd2);
      send_res(5'd2, 32'hA5A5_0002, 1'b1, 1'b0);
      send_res(5'd5, 32'h5A5A_0005, 1'b0, 1'b1);
      res_valid = 1'b0;
      tick();
      checks++;
      if (issue_ready !== 1'b1 || front_stall !== 1'b0 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL mismatch_end got irdy=%0b stall=%0b pending=%0d required 1 0 0",
                  issue_ready, front_stall, exp_q.size());
      end
   endtask

   task automatic test_max_lmul();
      issue_valid = 1'b1;
      issue_lmul  = 3'b111;
      issue_rdest = 5'd0;
      tick();
      checks++;
      if (front_stall !== 1'b1 || issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL max_issue got stall=%0b irdy=%0b required 1 0", front_stall, issue_ready);
      end
      for (int i = 0; i < 8; i++) begin
         send_res(5'(i), $urandom, 1'b1, i == 7);
         checks++;
         if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL max_hold_ready step %0d got irdy=%0b required 0", i, issue_ready);
         end
      end
      res_valid   = 1'b0;
      issue_rdest = 5'd9;
      tick();
      checks++;
      if (issue_ready !== 1'b1 || front_stall !== 1'b0) begin
         errors++;
         $display("FAIL max_after_done got irdy=%0b stall=%0b required 1 0", issue_ready, front_stall);
      end
      tick();
      checks++;
      if (issue_ready !== 1'b0 || front_stall !== 1'b1) begin
         errors++;
         $display("FAIL max_reissue got irdy=%0b stall=%0b required 0 1", issue_ready, front_stall);
      end
      issue_valid = 1'b0;
      // Second group with a one-cycle gap before every result.
      for (int i = 0; i < 8; i++) begin
         res_valid = 1'b0;
         res_rdest = 5'(9 + i);
         tick();
         checks++;
         if (wr_en !== 1'b0 || err_seq !== 1'b0 || group_done !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle step %0d got wr=%0b err=%0b done=%0b required 0 0 0",
                     i, wr_en, err_seq, group_done);
         end
         send_res(5'(9 + i), $urandom, 1'b1, i == 7);
      end
      res_valid = 1'b0;
      tick();
      checks++;
      if (exp_q.size() !== 0 || issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_drain got pending=%0d irdy=%0b required 0 1", exp_q.size(), issue_ready);
      end
   endtask

   task automatic test_idle_res();
      res_valid = 1'b1;
      res_rdest = 5'd0;
      res_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (res_ready !== 1'b0 || wr_en !== 1'b0 || err_seq !== 1'b0) begin
            errors++;
            $display("FAIL idle_res got rrdy=%0b wr=%0b err=%0b required 0 0 0", res_ready, wr_en, err_seq);
         end
      end
      res_valid = 1'b0;
      do_issue(3'b000, 5'd0);
      send_res(5'd0, 32'h1234_5678, 1'b1, 1'b1);
      res_valid = 1'b0;
      tick();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL idle_res_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_issue(3'b010, 5'd12);
      send_res(5'd12, $urandom, 1'b1, 1'b0);
      send_res(5'd13, $urandom, 1'b1, 1'b0);
      res_valid = 1'b1;
      res_rdest = 5'd14;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, err_seq, group_done, front_stall, res_ready, issue_ready, wr_addr, wr_data} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0}) begin
         errors++;
         $display("FAIL async_reset got wr=%0b err=%0b done=%0b stall=%0b rrdy=%0b irdy=%0b addr=%0d required all 0 except irdy=1",
                  wr_en, err_seq, group_done, front_stall, res_ready, issue_ready, wr_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (wr_en !== 1'b0 || group_done !== 1'b0 || err_seq !== 1'b0) begin
            errors++;
            $display("FAIL in_reset got wr=%0b done=%0b err=%0b required 0 0 0", wr_en, group_done, err_seq);
         end
      end
      @(negedge clk);
      rst_n       = 1'b1;
      res_valid   = 1'b0;
      issue_valid = 1'b1;
      issue_lmul  = 3'b000;
      issue_rdest = 5'd20;
      tick();
      issue_valid = 1'b0;
      checks++;
      if (front_stall !== 1'b1 || issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_issue got stall=%0b irdy=%0b required 1 0", front_stall, issue_ready);
      end
      send_res(5'd20, 32'hCAFE_0020, 1'b1, 1'b1);
      res_valid = 1'b0;
      tick();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL post_reset_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_lmul4();
      test_wrap();
      test_mismatch();
      test_max_lmul();
      test_idle_res();
      test_reset_mid();
      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vgroup_retire.md
VGROUP_RETIRE -- requirements
Module: vgroup_retire

Interface
REQ-001 Parameter DATA_W, default 32, width of one vector register result word.
REQ-002 Parameter MAX_LMUL, default 8, group size used for reserved/invalid LMUL encodings.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 issue_valid  input  1  new grouped instruction offered for retirement tracking.
REQ-006 issue_lmul  input  3  encoded LMUL (000=1, 001=2, 010=4, 011=8, 1xx=MAX_LMUL).
REQ-007 issue_rdest  input  5  base destination vector register of the group.
REQ-008 issue_ready  output  1  block can accept an instruction.
REQ-009 res_valid  input  1  ALU micro-op result offered.
REQ-010 res_rdest  input  5  destination register of the offered result.
REQ-011 res_data  input  DATA_W  result word.
REQ-012 res_ready  output  1  block accepts the offered result.
REQ-013 wr_en  output  1  vector register file write strobe.
REQ-014 wr_addr  output  5  register file write address.
REQ-015 wr_data  output  DATA_W  register file write data.
REQ-016 group_done  output  1  one-cycle pulse: whole group retired.
REQ-017 err_seq  output  1  one-cycle pulse: result rdest did not match expected register.
REQ-018 front_stall  output  1  front-end (IF1/IF2) stall request while a group is outstanding.

Function
REQ-019 The block SHALL implement states IDLE, COLLECT, DONE.
REQ-020 issue_ready SHALL be 1 only in IDLE; res_ready SHALL be 1 only in COLLECT.
REQ-021 Issue handshake (issue_valid & issue_ready) SHALL latch base=issue_rdest, total=decoded LMUL (1..8, 4 bits), count=0, and move IDLE->COLLECT.
REQ-022 Expected register SHALL be (base + count) modulo 32; wrap from v31 to v0 is legal and not an error.
REQ-023 Result handshake (res_valid & res_ready) SHALL increment count by 1 regardless of match.
REQ-024 On a matching handshake, wr_en, wr_addr=expected register, wr_data=res_data SHALL be asserted for exactly one cycle, in the cycle after the handshake.
REQ-025 On a mismatching handshake, wr_en SHALL stay 0 and err_seq SHALL pulse one cycle, in the cycle after the handshake.
REQ-026 The handshake that makes count equal total SHALL move COLLECT->DONE.
REQ-027 In DONE, group_done SHALL be 1 for exactly one cycle, coincident with the final write/err pulse, then the state SHALL return to IDLE.
REQ-028 front_stall SHALL be 1 in COLLECT and DONE, 0 in IDLE; total issue-to-release latency for LMUL=N with back-to-back results is N+1 cycles after the issue handshake.
REQ-029 res_valid while not in COLLECT SHALL be ignored (no write, no error, no count change).
REQ-030 issue_valid outside IDLE SHALL be ignored; the next issue is accepted no earlier than the cycle after group_done.
REQ-031 Gaps (res_valid low) during COLLECT SHALL hold count and all outputs idle.
REQ-032 LMUL=1 SHALL retire in one result handshake: COLLECT->DONE directly.

Reset
REQ-033 While rst_n=0: state=IDLE, count=0, base=0, total=0, wr_en=0, wr_addr=0, wr_data=0, group_done=0, err_seq=0, front_stall=0.
REQ-034 Reset asserted mid-group SHALL discard the group with no further writes or pulses; after release the block is in IDLE with issue_ready=1.

Verification
REQ-035 Issue lmul=010, rdest=4; results v4..v7 back-to-back -> writes to 4,5,6,7 on consecutive cycles, group_done with write to 7, front_stall high 5 cycles.
REQ-036 Issue lmul=011, rdest=28 -> expected order 28..31,0..3; all writes, no err_seq.
REQ-037 Issue lmul=001, rdest=2; results rdest=2 then 5 -> one write to v2, err_seq pulse on second, group_done still pulses.
REQ-038 Issue lmul=111, rdest=0 -> eight results required (MAX_LMUL); issue_valid held high throughout accepted only after group_done.
REQ-039 Issue lmul=010; after 2 results drop rst_n -> all outputs 0 asynchronously, no group_done; after release new issue accepted in first cycle.
REQ-040 res_valid=1 in IDLE with data 0xDEADBEEF -> res_ready=0, wr_en=0, err_seq=0.
